// File: rtl/expr_eval.sv
// expr_eval -- streaming evaluator for single-digit expressions with '+',
// '*' (binds tighter) and one level of parentheses. One ASCII character is
// consumed on every rising clock edge; the value of the prefix received so far
// is presented one cycle later whenever that prefix is a complete expression.
//
// Build option: define EXPR_EVAL_OVF_EN to enable sticky wrap detection on
// `ovf`. Without it `ovf` is tied low. `result` is the same in both builds.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   clr     in   1      asynchronous active-high reset back to S0
//   in      in   8      ASCII character, consumed every edge while clr is low
//   valid   out  1      prefix so far is a complete legal expression
//   result  out  WIDTH  value of the expression while valid, else 0
//   err     out  1      stream became illegal; sticky until clr
//   ovf     out  1      sticky arithmetic wrap flag (EXPR_EVAL_OVF_EN only)
//
// Timing contract: there is no handshake. A character is consumed on every
// edge with clr low; an idle upstream must present an illegal code, which
// drives the block into its absorbing error state. All outputs are decoded
// from registers, so nothing reaches the outputs combinationally from `in`.
module expr_eval #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S0   = 3'd0,  // start
    NUM  = 3'd1,  // outer operand done
    OP   = 3'd2,  // outer operator pending
    LP   = 3'd3,  // just after '('
    INUM = 3'd4,  // inner operand done
    IOP  = 3'd5,  // inner operator pending
    ERR  = 3'd6   // absorbing error
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] osum_q, osum_d;
  logic [WIDTH-1:0] oprod_q, oprod_d;
  logic [WIDTH-1:0] res_q;

  // Character classes. For ASCII digits the low nibble is the digit value.
  logic             is_digit, is_op, is_plus, is_lpar, is_rpar;
  logic [WIDTH-1:0] dig;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2B);
  assign is_op    = is_plus || (in == 8'h2A);
  assign is_lpar  = (in == 8'h28);
  assign is_rpar  = (in == 8'h29);
  assign dig      = WIDTH'(in[3:0]);

  // Shared arithmetic: digit multiply, term add, and the ')' fold-back that
  // multiplies the saved outer product by the finished inner sum.
  logic [WIDTH-1:0] dmul, iadd, cmul;

  assign dmul = prod_q * dig;
  assign iadd = sum_q + prod_q;
  assign cmul = oprod_q * iadd;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    osum_d  = osum_q;
    oprod_d = oprod_q;
    unique case (state_q)
      S0, OP: begin
        if (is_digit) begin
          prod_d  = dmul;
          state_d = NUM;
        end else if (is_lpar) begin
          osum_d  = sum_q;
          oprod_d = prod_q;
          sum_d   = '0;
          prod_d  = WIDTH'(1);
          state_d = LP;
        end else begin
          state_d = ERR;
        end
      end
      NUM, INUM: begin
        if (is_op) begin
          if (is_plus) begin
            sum_d  = iadd;
            prod_d = WIDTH'(1);
          end
          state_d = (state_q == NUM) ? OP : IOP;
        end else if (is_rpar && (state_q == INUM)) begin
          sum_d   = osum_q;
          prod_d  = cmul;
          state_d = NUM;
        end else begin
          state_d = ERR;
        end
      end
      LP, IOP: begin
        if (is_digit) begin
          prod_d  = dmul;
          state_d = INUM;
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = ERR;  // ERR and unused encodings stay put
    endcase
  end

`ifdef EXPR_EVAL_OVF_EN
  // Wrap detection recomputes the same operations at full precision and
  // flags any bits that the WIDTH-bit datapath discards.
  logic [2*WIDTH-1:0] dmul_w, cmul_w;
  logic [WIDTH:0]     iadd_w, res_w;
  logic               ovf_hit;
  logic               ovf_q;

  assign dmul_w = (2*WIDTH)'(prod_q) * (2*WIDTH)'(dig);
  assign iadd_w = {1'b0, sum_q} + {1'b0, prod_q};
  assign cmul_w = (2*WIDTH)'(oprod_q) * (2*WIDTH)'(iadd);
  assign res_w  = {1'b0, sum_d} + {1'b0, prod_d};

  always_comb begin
    ovf_hit = res_w[WIDTH];
    unique case (state_q)
      S0, OP, LP, IOP: if (is_digit) ovf_hit = ovf_hit | (|dmul_w[2*WIDTH-1:WIDTH]);
      NUM:             if (is_plus)  ovf_hit = ovf_hit | iadd_w[WIDTH];
      INUM: begin
        if (is_plus) ovf_hit = ovf_hit | iadd_w[WIDTH];
        if (is_rpar) ovf_hit = ovf_hit | iadd_w[WIDTH] | (|cmul_w[2*WIDTH-1:WIDTH]);
      end
      default: ;
    endcase
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S0;
      sum_q   <= '0;
      prod_q  <= WIDTH'(1);
      osum_q  <= '0;
      oprod_q <= WIDTH'(1);
      res_q   <= '0;
`ifdef EXPR_EVAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      osum_q  <= osum_d;
      oprod_q <= oprod_d;
      // Value of the current context as if the stream ended here.
      res_q   <= sum_d + prod_d;
`ifdef EXPR_EVAL_OVF_EN
      ovf_q   <= ovf_q | ovf_hit;
`endif
    end
  end

  assign valid  = (state_q == NUM);
  assign err    = (state_q == ERR);
  assign result = valid ? res_q : '0;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval. Two instances (WIDTH=32 and WIDTH=8) see the same
// character stream. A reference model keeps the accepted prefix as a list of
// characters, judges legality from the grammar (operand/operator alternation
// and parenthesis depth) and evaluates the whole prefix from scratch with
// modular arithmetic. Expected outputs go into per-instance queues; a monitor
// pops and compares them whenever outputs are sampled.
module tb_expr_eval;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] in_c = 8'h78;

  logic        v32, e32, o32;
  logic [31:0] r32;
  logic        v8, e8, o8;
  logic [7:0]  r8;

  expr_eval #(.WIDTH(32)) dut32 (
    .clk(clk), .clr(clr), .in(in_c),
    .valid(v32), .result(r32), .err(e32), .ovf(o32)
  );

  expr_eval #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .in(in_c),
    .valid(v8), .result(r8), .err(e8), .ovf(o8)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry layout: {valid, err, ovf, result}
  logic [34:0] exp_q32[$];
  logic [10:0] exp_q8[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  event        sample_ev;

  always @(negedge clk) -> sample_ev;

  initial begin : monitor
    logic [34:0] e32x;
    logic [10:0] e8x;
    forever begin
      @(sample_ev);
      if (exp_q32.size() > 0) begin
        e32x = exp_q32.pop_front();
        n_cmp++;
        if ({v32, e32, o32, r32} !== e32x) begin
          n_fail++;
          $display("FAIL w32 @%0t: got v=%0b e=%0b o=%0b r=%0d, want v=%0b e=%0b o=%0b r=%0d",
                   $time, v32, e32, o32, r32, e32x[34], e32x[33], e32x[32], e32x[31:0]);
        end
      end
      if (exp_q8.size() > 0) begin
        e8x = exp_q8.pop_front();
        n_cmp++;
        if ({v8, e8, o8, r8} !== e8x) begin
          n_fail++;
          $display("FAIL w8 @%0t: got v=%0b e=%0b o=%0b r=%0d, want v=%0b e=%0b o=%0b r=%0d",
                   $time, v8, e8, o8, r8, e8x[10], e8x[9], e8x[8], e8x[7:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] hist[$];   // legal characters accepted since clr
  bit         dead;      // stream has become illegal
  bit         m_ovf32, m_ovf8;

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  // Grammar position after the accepted prefix.
  function automatic void scan(output bit need_opnd, output int depth);
    need_opnd = 1'b1;
    depth     = 0;
    foreach (hist[i]) begin
      if (is_dig(hist[i]))     need_opnd = 1'b0;
      else if (hist[i] == "(") depth = 1;
      else if (hist[i] == ")") depth = 0;
      else                     need_opnd = 1'b1;
    end
  endfunction

  function automatic bit legal_next(input logic [7:0] c);
    bit need_opnd;
    int depth;
    scan(need_opnd, depth);
    if (need_opnd) return is_dig(c) || (c == "(" && depth == 0);
    return (c == "+") || (c == "*") || (c == ")" && depth == 1);
  endfunction

  function automatic bit complete();
    bit need_opnd;
    int depth;
    scan(need_opnd, depth);
    return !need_opnd && depth == 0;
  endfunction

  // Evaluate the prefix with w-bit wrapping; ov reports any operation whose
  // exact result did not fit, including the final "sum so far" addition.
  function automatic void eval_hist(input int w, output longint unsigned val, output bit ov);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned s[2];
    longint unsigned p[2];
    longint unsigned t;
    int d = 0;
    s[0] = 0; s[1] = 0; p[0] = 1; p[1] = 1;
    ov = 1'b0;
    foreach (hist[i]) begin
      if (is_dig(hist[i])) begin
        t = p[d] * longint'(hist[i] - 8'h30);
        ov |= (t > mask);
        p[d] = t & mask;
      end else if (hist[i] == "+") begin
        t = s[d] + p[d];
        ov |= (t > mask);
        s[d] = t & mask;
        p[d] = 1;
      end else if (hist[i] == "(") begin
        d = 1; s[1] = 0; p[1] = 1;
      end else if (hist[i] == ")") begin
        t = s[1] + p[1];
        ov |= (t > mask);
        t = p[0] * (t & mask);
        ov |= (t > mask);
        p[0] = t & mask;
        d = 0;
      end
    end
    t = s[d] + p[d];
    ov |= (t > mask);
    val = t & mask;
  endfunction

  task automatic model_reset();
    hist.delete();
    dead    = 1'b0;
    m_ovf32 = 1'b0;
    m_ovf8  = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] c);
    longint unsigned v32m, v8m;
    bit ov, vld, o32e, o8e;
    if (!dead) begin
      if (legal_next(c)) hist.push_back(c);
      else dead = 1'b1;
    end
    eval_hist(32, v32m, ov); m_ovf32 |= ov;
    eval_hist(8,  v8m,  ov); m_ovf8  |= ov;
    vld = !dead && complete();
`ifdef EXPR_EVAL_OVF_EN
    o32e = m_ovf32;
    o8e  = m_ovf8;
`else
    o32e = 1'b0;
    o8e  = 1'b0;
`endif
    exp_q32.push_back({vld, dead, o32e, vld ? v32m[31:0] : 32'd0});
    exp_q8.push_back({vld, dead, o8e, vld ? v8m[7:0] : 8'd0});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    in_c = c;
    @(posedge clk);
    model_step(c);
  endtask

  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_char(c);
    end
  endtask

  // Asynchronous clear raised mid-cycle; outputs are checked before the next
  // edge, and clr is held through one edge before releasing.
  task automatic do_clr();
    @(negedge clk);
    #1 clr = 1'b1;
    model_reset();
    #1;
    exp_q32.push_back(35'd0);
    exp_q8.push_back(11'd0);
    -> sample_ev;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  // Mostly grammar-following characters so long legal expressions occur,
  // with an occasional arbitrary character.
  function automatic logic [7:0] gen_char();
    string any = "0123456789+*()x# ";
    bit need_opnd;
    int depth;
    if ($urandom_range(0, 99) < 7) return any[$urandom_range(0, any.len() - 1)];
    if (dead) return 8'h30 + 8'($urandom_range(0, 9));
    scan(need_opnd, depth);
    if (need_opnd) begin
      if (depth == 0 && $urandom_range(0, 3) == 0) return "(";
      return 8'h30 + 8'($urandom_range(0, 9));
    end
    if (depth == 1 && $urandom_range(0, 2) == 0) return ")";
    return $urandom_range(0, 1) ? "+" : "*";
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    do_clr();

    send_str("1+2*3");
    do_clr(); send_str("(1+2)*3");
    do_clr(); send_str("2*(3+4)+1");
    do_clr(); send_str("1(5");
    do_clr(); send_str("(1+");
    do_clr(); send_str("5");
    do_clr(); send_str("9*9*9");
    do_clr(); send_str("()");
    do_clr(); send_str("((1)");
    do_clr(); send_str("+1");
    do_clr(); send_str("12");
    do_clr(); send_str("9*9*9*9*9*9*9*9*9*9*9+(9*9+9)");

    for (int n = 0; n < 60; n++) begin
      do_clr();
      for (int k = 0; k < $urandom_range(1, 16); k++) send_char(gen_char());
    end

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
